// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MIPS multiply/divide unit owning the HI/LO registers
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_x_i,
  input  logic [WIDTH-1:0] op_y_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d, x_q, x_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic is_div_q, is_div_d, sgn_res_q, sgn_res_d, sgn_rem_q, sgn_rem_d, y_zero_q, y_zero_d;
  logic done_q, done_d, dz_q, dz_d;
  logic accept, last, signed_op, x_neg, y_neg;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0] mul_t, rem_t;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, quo, rem, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_n;
  logic ge;
  assign accept    = state_q == IDLE && start_i && !abort_i;
  assign last      = cnt_q == CNT_W'(WIDTH-1);
  assign signed_op = !op_i[0];
  assign x_neg     = signed_op && op_x_i[WIDTH-1];
  assign y_neg     = signed_op && op_y_i[WIDTH-1];
  assign x_abs     = x_neg ? -op_x_i : op_x_i;
  assign y_abs     = y_neg ? -op_y_i : op_y_i;
  // one shift-add multiply step and one restoring divide step per cycle
  always_comb begin
    mul_t  = acc_lo_q[0] ? {1'b0, acc_hi_q} + {1'b0, b_q} : {1'b0, acc_hi_q};
    mul_hi = mul_t[WIDTH:1];
    mul_lo = {mul_t[0], acc_lo_q[WIDTH-1:1]};
    rem_t  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge     = rem_t >= {1'b0, b_q};
    div_hi = WIDTH'(ge ? rem_t - {1'b0, b_q} : rem_t);
    div_lo = {acc_lo_q[WIDTH-2:0], ge};
  end
  // sign correction and divide-by-zero override applied when leaving FIX
  always_comb begin
    prod_n = sgn_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo    = sgn_res_q ? -acc_lo_q : acc_lo_q;
    rem    = sgn_rem_q ? -acc_hi_q : acc_hi_q;
    res_hi = !is_div_q ? prod_n[2*WIDTH-1:WIDTH] : y_zero_q ? x_q : rem;
    res_lo = !is_div_q ? prod_n[WIDTH-1:0] : y_zero_q ? '1 : quo;
  end
  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FSM next state: abort always returns to IDLE
  always_comb begin
    state_d = abort_i ? IDLE
            : accept && !op_i[2] ? CALC
            : state_q == CALC && last ? FIX
            : state_q == FIX ? IDLE
            : state_q;
  end
  // FSM outputs
  always_comb begin
    busy_o     = state_q != IDLE;
    done_o     = done_q;
    div_zero_o = dz_q;
    hi_o       = hi_q;
    lo_o       = lo_q;
  end
  // datapath next state: operand latch, iteration, result write, MTHI/MTLO
  always_comb begin
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    b_d       = b_q;
    x_d       = x_q;
    is_div_d  = is_div_q;
    sgn_res_d = sgn_res_q;
    sgn_rem_d = sgn_rem_q;
    y_zero_d  = y_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (accept && !op_i[2]) begin
      cnt_d     = '0;
      is_div_d  = op_i[1];
      acc_hi_d  = '0;
      acc_lo_d  = op_i[1] ? x_abs : y_abs;
      b_d       = op_i[1] ? y_abs : x_abs;
      x_d       = op_x_i;
      sgn_res_d = x_neg ^ y_neg;
      sgn_rem_d = x_neg;
      y_zero_d  = op_y_i == '0;
    end else if (state_q == CALC) begin
      cnt_d    = cnt_q + 1'b1;
      acc_hi_d = is_div_q ? div_hi : mul_hi;
      acc_lo_d = is_div_q ? div_lo : mul_lo;
    end
    if (accept && op_i == 3'd4) hi_d = op_x_i;
    if (accept && op_i == 3'd5) lo_d = op_x_i;
    done_d = state_q == FIX && !abort_i;
    if (done_d) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
    dz_d = done_d ? is_div_q && y_zero_q : dz_q;
  end
  // datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      b_q       <= '0;
      x_q       <= '0;
      is_div_q  <= 1'b0;
      sgn_res_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      y_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      b_q       <= b_d;
      x_q       <= x_d;
      is_div_q  <= is_div_d;
      sgn_res_q <= sgn_res_d;
      sgn_rem_q <= sgn_rem_d;
      y_zero_q  <= y_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for alu_muldiv against an arithmetic model
module tb_alu_muldiv;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] x = '0, y = '0;
  logic busy, done, dz;
  logic [W-1:0] hi, lo;
  alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .op_x_i(x), .op_y_i(y),
    .abort_i(abort), .busy_o(busy), .done_o(done), .div_zero_o(dz), .hi_o(hi), .lo_o(lo)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic dz;
    int acc;
    int op;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] pre_hi, pre_lo;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, want);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sp;
    logic [63:0] p;
    int sa, sb;
    e.dz = 1'b0;
    e.op = int'(o);
    e.acc = 0;
    sa = a;
    sb = b;
    if (o == 3'd0) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p = sp;
      {e.hi, e.lo} = p;
    end else if (o == 3'd1) begin
      p = {32'b0, a} * {32'b0, b};
      {e.hi, e.lo} = p;
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else if (o == 3'd2 && a == 32'h8000_0000 && b == '1) begin
      e.hi = '0;
      e.lo = a;
    end else if (o == 3'd2) begin
      e.lo = sa / sb;
      e.hi = sa % sb;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("op%0d_hi", mon_e.op), 64'(hi), 64'(mon_e.hi));
        chk($sformatf("op%0d_lo", mon_e.op), 64'(lo), 64'(mon_e.lo));
        chk($sformatf("op%0d_div_zero", mon_e.op), 64'(dz), 64'(mon_e.dz));
        chk($sformatf("op%0d_latency", mon_e.op), 64'(cyc - mon_e.acc), 64'(W + 1));
        chk("busy_low_at_done", 64'(busy), 64'(0));
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("busy_timeout", 64'(busy), 64'(0));
    pre_hi = hi;
    pre_lo = lo;
    start = 1'b1;
    op = o;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    if (o < 3'd4) begin
      e = model(o, a, b);
      e.acc = cyc;
      exp_q.push_back(e);
      chk("accept_busy", 64'(busy), 64'(1));
    end else if (o == 3'd4) begin
      chk("mthi_hi", 64'(hi), 64'(a));
      chk("mthi_lo", 64'(lo), 64'(pre_lo));
      chk("mthi_done", 64'(done), 64'(0));
    end else if (o == 3'd5) begin
      chk("mtlo_lo", 64'(lo), 64'(a));
      chk("mtlo_hi", 64'(hi), 64'(pre_hi));
      chk("mtlo_done", 64'(done), 64'(0));
    end else begin
      chk("nop_hilo", {hi, lo}, {pre_hi, pre_lo});
      chk("nop_busy", 64'(busy), 64'(0));
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] o;
    logic [W-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {59'(0), busy, done, dz, 2'(0)}, 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    rst_n = 1'b1;
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(3'd3, 32'h0000_0007, 32'h0000_0000);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("div_zero_holds", 64'(dz), 64'(1));
    issue(3'd3, 32'h0000_0064, 32'h0000_0007);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    issue(3'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op = 3'd2;
    x = 32'd100;
    y = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored_start_busy", 64'(busy), 64'(1));
    drain();
    issue(3'd4, 32'h1234_5678, 32'h0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    issue(3'd2, 32'd1000, 32'd3);
    pre_hi = hi;
    pre_lo = lo;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_calc_busy", 64'(busy), 64'(0));
    chk("abort_calc_hilo", {hi, lo}, {pre_hi, pre_lo});
    repeat (W + 5) @(posedge clk);
    #1;
    chk("abort_calc_hilo_later", {hi, lo}, {pre_hi, pre_lo});
    issue(3'd1, 32'hDEAD_BEEF, 32'h0000_0010);
    repeat (W) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_fix_busy", 64'(busy), 64'(0));
    chk("abort_fix_hilo", {hi, lo}, {pre_hi, pre_lo});
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    op = 3'd4;
    x = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    op = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_start_busy", 64'(busy), 64'(0));
    chk("abort_idle_start_hilo", {hi, lo}, {pre_hi, pre_lo});
    issue(3'd0, 32'h0000_0055, 32'hFFFF_FF00);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("midop_reset_outputs", {59'(0), busy, done, dz, 2'(0)}, 64'(0));
    chk("midop_reset_hilo", {hi, lo}, 64'(0));
    rst_n = 1'b1;
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = '1;
        default: ;
      endcase
      issue(o, a, b);
    end
    drain();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
